// File: rtl/fsm_nth_one_detector_if.sv
// Control/status bundle of the Nth-one detector: stimulus and enables in,
// pulse, phase, hit counter and flags out.
interface fsm_nth_one_detector_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic             en;
  logic             clr;
  logic             mode;
  logic             din;
  logic             dout;
  logic [PW-1:0]    phase;
  logic [CNT_W-1:0] hit_cnt;
  logic             busy;
  logic             ovf;

  modport master (
    output en, clr, mode, din,
    input  dout, phase, hit_cnt, busy, ovf
  );

  modport slave (
    input  en, clr, mode, din,
    output dout, phase, hit_cnt, busy, ovf
  );
endinterface

// File: rtl/fsm_nth_one_detector.sv
// Counts accepted din=1 samples and emits a same-cycle Mealy pulse on every
// Nth one, with a saturating pulse counter and a sticky overflow flag.
module fsm_nth_one_detector #(
  parameter int N     = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  fsm_nth_one_detector_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 1) begin : g_bad_n
    $error("fsm_nth_one_detector: N must be >= 1");
  end

  localparam logic [1:0]       S_IDLE  = 2'b01;
  localparam logic [1:0]       S_RUN   = 2'b10;
  localparam logic [PW-1:0]    LAST    = PW'(N - 1);
  localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             ovf_q, ovf_d;
  logic             run_s;
  logic             accept_s;
  logic             pulse_s;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.clr) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the pulse is gated by state so an async reset kills it at once.
  always_comb begin
    run_s    = (state_q == S_RUN);
    accept_s = run_s & bus.en & ~bus.clr & bus.din;
    pulse_s  = accept_s & (phase_q == LAST);
  end

  assign bus.dout    = pulse_s;
  assign bus.busy    = run_s;
  assign bus.phase   = phase_q;
  assign bus.hit_cnt = hit_q;
  assign bus.ovf     = ovf_q;

  // Counter next-values: clr wins, then enable, then din.
  always_comb begin
    phase_d = phase_q;
    hit_d   = hit_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      phase_d = '0;
      hit_d   = '0;
      ovf_d   = 1'b0;
    end else if (run_s && bus.en) begin
      if (bus.din) begin
        if (phase_q == LAST) begin
          phase_d = '0;
          if (hit_q == HIT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            hit_d = hit_q + CNT_W'(1);
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end else if (bus.mode) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q;
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      hit_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      hit_q   <= hit_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
